spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SPI_FREQ, default 100_000, sclk frequency in Hz; HALF = CLK_FREQ/(2*SPI_FREQ) SHALL be >= 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, maximum frame length in bits.
REQ-004 SHALL have parameter NUM_CS, default 4, number of chip selects, 1..16.
REQ-005 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-006 SHALL have port arstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port spi_start, input, 1, transfer request, sampled each clk.
REQ-008 SHALL have port data_send, input, DATA_WIDTH, transmit word, right-aligned.
REQ-009 SHALL have port frame_len, input, clog2(DATA_WIDTH)+1, bits per frame, 1..DATA_WIDTH.
REQ-010 SHALL have ports cpol, cpha, lsb_first, inputs, 1 each, per-transfer mode.
REQ-011 SHALL have port cs_sel, input, clog2(NUM_CS) (min 1), target slave index.
REQ-012 SHALL have ports sclk, output, 1; csn, output, NUM_CS, active-low selects; mosi, output, 1; miso, input, 1.
REQ-013 SHALL have ports busy, output, 1; spi_done, output, 1; err, output, 1; data_recv, output, DATA_WIDTH.

Function
REQ-014 SHALL use states IDLE, SETUP, XFER, HOLD, DONE; IDLE->SETUP on accepted start; SETUP->XFER after HALF clks; XFER->HOLD after 2*frame_len half-periods; HOLD->DONE after HALF clks; DONE->IDLE after 1 clk.
REQ-015 SHALL accept spi_start only in IDLE; data_send, frame_len, cpol, cpha, lsb_first, cs_sel latched on the accepting edge; spi_start outside IDLE ignored.
REQ-016 SHALL reject a start with frame_len==0, frame_len>DATA_WIDTH or cs_sel>=NUM_CS: stay IDLE, pulse err one clk, no csn activity.
REQ-017 SHALL drive csn[cs_sel] low from the clk after acceptance through end of HOLD; all other csn bits high always.
REQ-018 SHALL hold sclk at latched cpol outside XFER, toggling every HALF clks in XFER, producing exactly frame_len cycles.
REQ-019 With cpha=0 SHALL present first bit on mosi on entry to SETUP, sample miso on each leading edge, shift on each trailing edge.
REQ-020 With cpha=1 SHALL shift mosi on each leading edge (first bit on first leading edge) and sample miso on each trailing edge.
REQ-021 SHALL transmit bit frame_len-1 first when lsb_first=0, bit 0 first when lsb_first=1.
REQ-022 SHALL assemble received bits so data_recv is right-aligned in transmit bit order, upper bits zero.
REQ-023 SHALL update data_recv only in DONE, held stable until next DONE.
REQ-024 SHALL pulse spi_done high exactly one clk in DONE; busy high from SETUP through DONE.
REQ-025 SHALL drive mosi 0 while IDLE.
REQ-026 SHALL accept a new start in the clk after DONE (back-to-back), giving csn high for at least 1 clk between frames.

Reset
REQ-027 On arstn low SHALL immediately force state IDLE, sclk=CPOL-latch 0, csn all ones, mosi 0, busy 0, spi_done 0, err 0, data_recv 0, counters 0.
REQ-028 Reset mid-transfer SHALL abort without spi_done; first start after release behaves as from power-up.

Configuration
REQ-029 SHALL compile internal loopback when SPI_MASTER_MULTI_LOOPBACK_EN is defined: extra input loopback, 1; when high, received bits take mosi instead of miso, sclk/csn/mosi pins unchanged.
REQ-030 Without SPI_MASTER_MULTI_LOOPBACK_EN SHALL have no loopback port and always sample miso.

Verification
REQ-031 CLK_FREQ=50M, SPI_FREQ=5M (HALF=5), mode 0, cs_sel=2, frame_len=8, data_send=8'hA5, miso tied to mosi -> 8 sclk pulses, mosi 1,0,1,0,0,1,0,1, only csn[2] low, data_recv=8'hA5, one spi_done pulse.
REQ-032 Mode 3, lsb_first=1, frame_len=5, data_send=5'b10011, miso=1 -> sclk idles 1, mosi 1,1,0,0,1, data_recv=8'h1F.
REQ-033 cs_sel=4 (NUM_CS=4) or frame_len=0 -> err pulse 1 clk, csn stays 4'hF, busy 0.
REQ-034 spi_start held high through a transfer -> second frame starts clk after DONE, csn high >= 1 clk between frames, spi_start during XFER not double-counted.
REQ-035 arstn low at 3rd sclk edge -> csn 4'hF, sclk=0, busy 0 same cycle, no spi_done; next start completes normally.
REQ-036 With SPI_MASTER_MULTI_LOOPBACK_EN, loopback=1, miso=0, data_send=8'h3C -> data_recv=8'h3C.

Source files
------------

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with per-transfer mode, length, bit order, slave.
// Define SPI_MASTER_MULTI_LOOPBACK_EN to add a loopback input (rx from mosi).
module spi_master_multi #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SPI_FREQ   = 100_000,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  localparam int LW  = $clog2(DATA_WIDTH) + 1,
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  spi_start,
  input  logic [DATA_WIDTH-1:0] data_send,
  input  logic [LW-1:0]         frame_len,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [CSW-1:0]        cs_sel,
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic                  miso,
  output logic                  sclk,
  output logic [NUM_CS-1:0]     csn,
  output logic                  mosi,
  output logic                  busy,
  output logic                  spi_done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] data_recv
);
  localparam int HALF = CLK_FREQ / (2 * SPI_FREQ);
  localparam int CW   = $clog2(HALF);
  localparam int EW   = LW + 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, XFER, HOLD, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [LW-1:0]         bit_q, bit_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  err_q, err_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic [CSW-1:0]        cs_q, cs_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] recv_q, recv_d;

  logic [LW-1:0]         ord_cur, ord_nxt, ord_first;
  logic [DATA_WIDTH-1:0] oh_cur, rx_bit;
  logic                  tx_cur, tx_nxt, tx_first;
  logic                  bad_req, half_end, lead, last_bit, rx_in;
  logic [EW-1:0]         last_edge;

`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  assign rx_in = loopback ? mosi_q : miso;
`else
  assign rx_in = miso;
`endif

  // Bit k of the frame sits at the same word position on tx and rx.
  assign ord_cur   = lsb_q ? bit_q
                           : len_q - LW'(1) - bit_q;
  assign ord_nxt   = lsb_q ? bit_q + LW'(1)
                           : len_q - LW'(2) - bit_q;
  assign ord_first = lsb_first ? '0
                               : frame_len - LW'(1);
  assign oh_cur    = DATA_WIDTH'(1) << ord_cur;
  assign tx_cur    = |(data_q & oh_cur);
  assign tx_nxt    = |(data_q & (DATA_WIDTH'(1) << ord_nxt));
  assign tx_first  = |(data_send & (DATA_WIDTH'(1) << ord_first));
  assign rx_bit    = {DATA_WIDTH{rx_in}} & oh_cur;

  assign bad_req   = (frame_len == '0)
                  || (frame_len > LW'(DATA_WIDTH))
                  || ({{(32-CSW){1'b0}}, cs_sel} >= 32'(NUM_CS));
  assign half_end  = (cnt_q == CW'(HALF - 1));
  assign lead      = ~edge_q[0];
  assign last_bit  = (bit_q == len_q - LW'(1));
  assign last_edge = {len_q, 1'b0} - EW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    len_d   = len_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    err_d   = 1'b0;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    cs_d    = cs_q;
    data_d  = data_q;
    rx_d    = rx_q;
    recv_d  = recv_q;
    unique case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        cnt_d  = '0;
        edge_d = '0;
        bit_d  = '0;
        if (spi_start) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            state_d = SETUP;
            data_d  = data_send;
            len_d   = frame_len;
            cpha_d  = cpha;
            lsb_d   = lsb_first;
            cs_d    = cs_sel;
            rx_d    = '0;
            sclk_d  = cpol;
            mosi_d  = cpha ? 1'b0 : tx_first;
          end
        end
      end
      SETUP: begin
        cnt_d = cnt_q + CW'(1);
        if (half_end) begin
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        cnt_d = cnt_q + CW'(1);
        if (half_end) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          if (!cpha_q) begin
            if (lead) begin
              rx_d = rx_q | rx_bit;
            end else if (!last_bit) begin
              bit_d  = bit_q + LW'(1);
              mosi_d = tx_nxt;
            end
          end else begin
            if (lead) begin
              mosi_d = tx_cur;
            end else begin
              rx_d  = rx_q | rx_bit;
              bit_d = bit_q + LW'(1);
            end
          end
          if (edge_q == last_edge) state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (half_end) begin
          cnt_d   = '0;
          state_d = DONE;
          recv_d  = rx_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        mosi_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      bit_q   <= '0;
      len_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      err_q   <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      cs_q    <= '0;
      data_q  <= '0;
      rx_q    <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      err_q   <= err_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      cs_q    <= cs_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
      recv_q  <= recv_d;
    end
  end

  always_comb begin
    csn = '1;
    if (state_q inside {SETUP, XFER, HOLD}) begin
      csn = ~(NUM_CS'(1) << cs_q);
    end
  end

  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign busy      = (state_q != IDLE);
  assign spi_done  = (state_q == DONE);
  assign err       = err_q;
  assign data_recv = recv_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed checks of spi_master_multi at HALF=5.
// Covers modes, bit order, lengths, rejects, back-to-back and reset abort.
module tb_spi_master_multi;
  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       spi_start = 1'b0;
  logic       spi_start3 = 1'b0;
  logic [7:0] data_send = '0;
  logic [3:0] frame_len = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic [1:0] cs_sel = '0;
  logic [1:0] cs_sel3 = '0;
  logic       loopback = 1'b0;
  logic       tie = 1'b0;
  logic       miso_val = 1'b0;
  logic       miso;
  logic       sclk, mosi, busy, spi_done, err;
  logic [3:0] csn;
  logic [7:0] data_recv;
  logic       sclk3, mosi3, busy3, done3, err3;
  logic [2:0] csn3;
  logic [7:0] recv3;
  int         total = 0;
  int         bad = 0;

  assign miso = tie ? mosi : miso_val;

  always #5 clk = ~clk;

  spi_master_multi #(
    .CLK_FREQ(50_000_000), .SPI_FREQ(5_000_000),
    .DATA_WIDTH(8), .NUM_CS(4)
  ) u_dut (
    .clk(clk), .arstn(arstn), .spi_start(spi_start),
    .data_send(data_send), .frame_len(frame_len),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .cs_sel(cs_sel),
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .miso(miso), .sclk(sclk), .csn(csn), .mosi(mosi),
    .busy(busy), .spi_done(spi_done), .err(err),
    .data_recv(data_recv)
  );

  spi_master_multi #(
    .CLK_FREQ(50_000_000), .SPI_FREQ(5_000_000),
    .DATA_WIDTH(8), .NUM_CS(3)
  ) u_dut3 (
    .clk(clk), .arstn(arstn), .spi_start(spi_start3),
    .data_send(data_send), .frame_len(frame_len),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .cs_sel(cs_sel3),
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .miso(miso_val), .sclk(sclk3), .csn(csn3), .mosi(mosi3),
    .busy(busy3), .spi_done(done3), .err(err3),
    .data_recv(recv3)
  );

  // Stimulus driver: starts one frame and records what the pins did.
  task automatic run_xfer(
    input  logic [7:0] d, input logic [3:0] len,
    input  logic pol, input logic pha, input logic lsb,
    input  logic [1:0] cs,
    output int nlead, output logic [15:0] seq,
    output int nlow, output int ndone,
    output logic csn_bad, output logic tmo, output logic stable
  );
    logic [7:0] prev_recv;
    logic [3:0] want;
    logic       ps;
    want = 4'hF;
    want[cs] = 1'b0;
    prev_recv = data_recv;
    nlead = 0; seq = '0; nlow = 0; ndone = 0;
    csn_bad = 1'b0; tmo = 1'b1; stable = 1'b1;
    data_send = d; frame_len = len;
    cpol = pol; cpha = pha; lsb_first = lsb;
    cs_sel = cs; spi_start = 1'b1;
    ps = sclk;
    @(negedge clk);
    spi_start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (csn === want) nlow++;
      else if (csn !== 4'hF) csn_bad = 1'b1;
      if (ps == pol && sclk != pol) begin
        nlead++;
        seq = {seq[14:0], mosi};
      end
      ps = sclk;
      if (spi_done === 1'b1) begin
        ndone++;
        tmo = 1'b0;
        break;
      end
      if (data_recv !== prev_recv) stable = 1'b0;
      @(negedge clk);
    end
    repeat (3) begin
      @(negedge clk);
      if (spi_done === 1'b1) ndone++;
      if (csn !== 4'hF) csn_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    total++;
    if (csn !== 4'hF) begin
      bad++; $display("FAIL rst_csn got=%h want=f", csn);
    end
    total++;
    if (sclk !== 1'b0 || mosi !== 1'b0) begin
      bad++;
      $display("FAIL rst_pins got sclk=%b mosi=%b want 0 0", sclk, mosi);
    end
    total++;
    if (busy !== 1'b0 || spi_done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL rst_flags got busy=%b done=%b err=%b want 0 0 0",
               busy, spi_done, err);
    end
    total++;
    if (data_recv !== 8'h00) begin
      bad++; $display("FAIL rst_recv got=%h want=00", data_recv);
    end
  endtask

  task automatic test_mode0();
    int nl, nw, nd; logic [15:0] sq; logic cb, to, st;
    tie = 1'b1;
    run_xfer(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 2'd2,
             nl, sq, nw, nd, cb, to, st);
    total++;
    if (to !== 1'b0) begin
      bad++; $display("FAIL m0_timeout got=%b want=0", to);
    end
    total++;
    if (nl !== 8 || sq[7:0] !== 8'hA5) begin
      bad++;
      $display("FAIL m0_mosi got n=%0d seq=%h want n=8 seq=a5", nl, sq[7:0]);
    end
    total++;
    if (nw !== 90 || cb !== 1'b0) begin
      bad++;
      $display("FAIL m0_csn got low=%0d bad=%b want 90 0", nw, cb);
    end
    total++;
    if (data_recv !== 8'hA5 || nd !== 1 || st !== 1'b1) begin
      bad++;
      $display("FAIL m0_recv got=%h done=%0d stable=%b want a5 1 1",
               data_recv, nd, st);
    end
    total++;
    if (sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL m0_idle got sclk=%b mosi=%b busy=%b want 0 0 0",
               sclk, mosi, busy);
    end
  endtask

  task automatic test_mode3_lsb();
    int nl, nw, nd; logic [15:0] sq; logic cb, to, st;
    tie = 1'b0; miso_val = 1'b1;
    run_xfer(8'h13, 4'd5, 1'b1, 1'b1, 1'b1, 2'd0,
             nl, sq, nw, nd, cb, to, st);
    total++;
    if (nl !== 5 || sq[4:0] !== 5'b11001) begin
      bad++;
      $display("FAIL m3_mosi got n=%0d seq=%b want n=5 seq=11001",
               nl, sq[4:0]);
    end
    total++;
    if (data_recv !== 8'h1F || nd !== 1 || to !== 1'b0) begin
      bad++;
      $display("FAIL m3_recv got=%h done=%0d want 1f 1", data_recv, nd);
    end
    total++;
    if (nw !== 60 || cb !== 1'b0 || st !== 1'b1) begin
      bad++;
      $display("FAIL m3_csn got low=%0d bad=%b stable=%b want 60 0 1",
               nw, cb, st);
    end
    total++;
    if (sclk !== 1'b1) begin
      bad++; $display("FAIL m3_sclk_idle got=%b want=1", sclk);
    end
    miso_val = 1'b0;
  endtask

  task automatic test_mode2_lsb();
    int nl, nw, nd; logic [15:0] sq; logic cb, to, st;
    tie = 1'b1;
    run_xfer(8'h34, 4'd6, 1'b1, 1'b0, 1'b1, 2'd3,
             nl, sq, nw, nd, cb, to, st);
    total++;
    if (nl !== 6 || sq[5:0] !== 6'b001011) begin
      bad++;
      $display("FAIL m2_mosi got n=%0d seq=%b want n=6 seq=001011",
               nl, sq[5:0]);
    end
    total++;
    if (data_recv !== 8'h34 || nw !== 70 || nd !== 1 || to !== 1'b0) begin
      bad++;
      $display("FAIL m2_recv got=%h low=%0d done=%0d want 34 70 1",
               data_recv, nw, nd);
    end
  endtask

  task automatic test_short_frames();
    int nl, nw, nd; logic [15:0] sq; logic cb, to, st;
    tie = 1'b1;
    run_xfer(8'hF6, 4'd4, 1'b0, 1'b1, 1'b0, 2'd1,
             nl, sq, nw, nd, cb, to, st);
    total++;
    if (nl !== 4 || sq[3:0] !== 4'b0110) begin
      bad++;
      $display("FAIL len4_mosi got n=%0d seq=%b want n=4 seq=0110",
               nl, sq[3:0]);
    end
    total++;
    if (data_recv !== 8'h06 || nw !== 50 || cb !== 1'b0) begin
      bad++;
      $display("FAIL len4_recv got=%h low=%0d want 06 50", data_recv, nw);
    end
    run_xfer(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 2'd2,
             nl, sq, nw, nd, cb, to, st);
    total++;
    if (nl !== 1 || sq[0] !== 1'b1 || nw !== 20) begin
      bad++;
      $display("FAIL len1_xfer got n=%0d bit=%b low=%0d want 1 1 20",
               nl, sq[0], nw);
    end
    total++;
    if (data_recv !== 8'h01 || nd !== 1 || to !== 1'b0) begin
      bad++;
      $display("FAIL len1_recv got=%h done=%0d want 01 1", data_recv, nd);
    end
  endtask

  task automatic test_reject();
    logic [3:0] lens [2];
    lens[0] = 4'd0;
    lens[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      frame_len = lens[k]; cs_sel = 2'd1; spi_start = 1'b1;
      @(negedge clk);
      spi_start = 1'b0;
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || csn !== 4'hF) begin
        bad++;
        $display("FAIL rej_len%0d got err=%b busy=%b csn=%h want 1 0 f",
                 lens[k], err, busy, csn);
      end
      @(negedge clk);
      total++;
      if (err !== 1'b0 || busy !== 1'b0 || csn !== 4'hF) begin
        bad++;
        $display("FAIL rej_len%0d_after got err=%b busy=%b csn=%h want 0 0 f",
                 lens[k], err, busy, csn);
      end
    end
  endtask

  task automatic test_cs_reject();
    logic to;
    frame_len = 4'd8; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    data_send = 8'hFF; miso_val = 1'b0;
    cs_sel3 = 2'd3; spi_start3 = 1'b1;
    @(negedge clk);
    spi_start3 = 1'b0;
    total++;
    if (err3 !== 1'b1 || busy3 !== 1'b0 || csn3 !== 3'b111) begin
      bad++;
      $display("FAIL rej_cs got err=%b busy=%b csn=%b want 1 0 111",
               err3, busy3, csn3);
    end
    @(negedge clk);
    cs_sel3 = 2'd2; spi_start3 = 1'b1;
    @(negedge clk);
    spi_start3 = 1'b0;
    total++;
    if (err3 !== 1'b0 || busy3 !== 1'b1 || csn3 !== 3'b011) begin
      bad++;
      $display("FAIL cs2_accept got err=%b busy=%b csn=%b want 0 1 011",
               err3, busy3, csn3);
    end
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done3 === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    @(negedge clk);
    total++;
    if (to !== 1'b0 || recv3 !== 8'h00 || sclk3 !== 1'b0 || mosi3 !== 1'b0) begin
      bad++;
      $display("FAIL cs2_done got tmo=%b recv=%h sclk=%b mosi=%b want 0 00 0 0",
               to, recv3, sclk3, mosi3);
    end
  endtask

  task automatic test_back_to_back();
    int  nd;
    logic to;
    tie = 1'b1; data_send = 8'h5A; frame_len = 4'd8;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; cs_sel = 2'd2;
    spi_start = 1'b1;
    nd = 0; to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (spi_done === 1'b1) begin
        nd++; to = 1'b0;
        break;
      end
    end
    total++;
    if (to !== 1'b0) begin
      bad++; $display("FAIL b2b_first got tmo=%b want=0", to);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || csn !== 4'hF) begin
      bad++;
      $display("FAIL b2b_gap got busy=%b csn=%h want 0 f", busy, csn);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || csn !== 4'b1011) begin
      bad++;
      $display("FAIL b2b_restart got busy=%b csn=%h want 1 b", busy, csn);
    end
    spi_start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (spi_done === 1'b1) begin
        nd++; to = 1'b0;
        break;
      end
    end
    repeat (200) begin
      @(negedge clk);
      if (spi_done === 1'b1) nd++;
    end
    total++;
    if (to !== 1'b0 || nd !== 2 || data_recv !== 8'h5A || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_count got tmo=%b done=%0d recv=%h busy=%b want 0 2 5a 0",
               to, nd, data_recv, busy);
    end
  endtask

  task automatic test_reset_mid();
    int edges, nd, nl, nw, nx;
    logic ps, to, cb, st;
    logic [15:0] sq;
    tie = 1'b1; data_send = 8'hA5; frame_len = 4'd8;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; cs_sel = 2'd2;
    spi_start = 1'b1;
    @(negedge clk);
    spi_start = 1'b0;
    edges = 0; ps = sclk; to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (sclk !== ps) edges++;
      ps = sclk;
      if (edges == 3) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (to !== 1'b0 || sclk !== 1'b1) begin
      bad++;
      $display("FAIL rmid_edge got tmo=%b sclk=%b want 0 1", to, sclk);
    end
    arstn = 1'b0;
    #1;
    total++;
    if (csn !== 4'hF || sclk !== 1'b0 || busy !== 1'b0 || spi_done !== 1'b0) begin
      bad++;
      $display("FAIL rmid_abort got csn=%h sclk=%b busy=%b done=%b want f 0 0 0",
               csn, sclk, busy, spi_done);
    end
    @(negedge clk);
    arstn = 1'b1;
    nd = 0;
    repeat (300) begin
      @(negedge clk);
      if (spi_done === 1'b1) nd++;
    end
    total++;
    if (nd !== 0 || busy !== 1'b0 || data_recv !== 8'h00) begin
      bad++;
      $display("FAIL rmid_nodone got done=%0d busy=%b recv=%h want 0 0 00",
               nd, busy, data_recv);
    end
    run_xfer(8'h96, 4'd8, 1'b0, 1'b0, 1'b0, 2'd1,
             nl, sq, nw, nx, cb, to, st);
    total++;
    if (sq[7:0] !== 8'h96 || data_recv !== 8'h96 || nw !== 90 || nx !== 1) begin
      bad++;
      $display("FAIL rmid_next got seq=%h recv=%h low=%0d done=%0d want 96 96 90 1",
               sq[7:0], data_recv, nw, nx);
    end
  endtask

`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  task automatic test_loopback();
    int nl, nw, nd; logic [15:0] sq; logic cb, to, st;
    tie = 1'b0; miso_val = 1'b0; loopback = 1'b1;
    run_xfer(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 2'd0,
             nl, sq, nw, nd, cb, to, st);
    total++;
    if (data_recv !== 8'h3C || sq[7:0] !== 8'h3C || nd !== 1) begin
      bad++;
      $display("FAIL loopback got recv=%h seq=%h done=%0d want 3c 3c 1",
               data_recv, sq[7:0], nd);
    end
    loopback = 1'b0;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    arstn = 1'b1;
    @(negedge clk);
    test_mode0();
    test_mode3_lsb();
    test_mode2_lsb();
    test_short_frames();
    test_reject();
    test_cs_reject();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    test_loopback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
